// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: FSM states, grant kinds and the controller address width.
package vram_pkg;
  localparam int MC_ADDR_W = 23;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_VDP, GNT_HR, GNT_REF} grant_t;
endpackage

// File: rtl/vram_arbiter_refresh_scheduler.sv
// Refresh credit generator: one credit every REFRESH_INTERVAL clocks, debt saturating at 7.
module refresh_scheduler #(
  parameter int REFRESH_INTERVAL = 840,
  parameter int MAX_PENDING      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       consume,
  output logic [2:0] debt,
  output logic       urgent,
  output logic       pending
);
  localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [CNT_W-1:0] cnt;
  logic             credit;

  assign credit = (cnt == CNT_W'(REFRESH_INTERVAL - 1));

  // A credit and a consume landing together cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      debt <= '0;
    end else begin
      cnt <= credit ? '0 : cnt + CNT_W'(1);
      if (credit && !consume && debt != 3'd7)
        debt <= debt + 3'd1;
      else if (consume && !credit && debt != 3'd0)
        debt <= debt - 3'd1;
    end
  end

  assign urgent  = (debt >= 3'(MAX_PENDING));
  assign pending = (debt != 3'd0);
endmodule

// File: rtl/vram_arbiter.sv
// Sequences the single memory_controller port between VDP byte accesses, high-res 32-bit
// fetches and refresh, using a req/ack handshake per client.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 840,
  parameter int MAX_PENDING      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vdp_req,
  input  logic                 vdp_we,
  input  logic [16:0]          vdp_addr,
  input  logic [7:0]           vdp_wdata,
  output logic [7:0]           vdp_rdata,
  output logic                 vdp_ack,
  input  logic                 hr_req,
  input  logic [16:0]          hr_addr,
  output logic [31:0]          hr_rdata,
  output logic                 hr_ack,
  output logic                 mc_read,
  output logic                 mc_write,
  output logic                 mc_refresh,
  output logic [MC_ADDR_W-1:0] mc_addr,
  output logic [15:0]          mc_din,
  output logic [1:0]           mc_wdm,
  input  logic [15:0]          mc_dout,
  input  logic [31:0]          mc_dout32,
  input  logic                 mc_busy,
  output logic [2:0]           refresh_debt,
  output arb_state_t           dbg_state
);
  // Handshake: a client raises req and holds it (with its fields) until it sees a 1-cycle
  // ack; read data is valid in the ack cycle. A req still high after ack is a new request.

  arb_state_t           state, state_nxt;
  grant_t               grant, gnt_nxt;
  logic                 consume, urgent, pending;
  logic                 lat_we, lat_hi;
  logic [MC_ADDR_W-1:0] lat_addr;
  logic [15:0]          lat_din;
  logic [1:0]           lat_wdm;
  logic                 issue;

  refresh_scheduler #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL),
    .MAX_PENDING     (MAX_PENDING)
  ) u_refresh (
    .clk    (clk),
    .reset  (reset),
    .consume(consume),
    .debt   (refresh_debt),
    .urgent (urgent),
    .pending(pending)
  );

  always_comb begin
    state_nxt = state;
    gnt_nxt   = GNT_NONE;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        if (!mc_busy) begin
          if (urgent)       gnt_nxt = GNT_REF;
          else if (hr_req)  gnt_nxt = GNT_HR;
          else if (vdp_req) gnt_nxt = GNT_VDP;
          else if (pending) gnt_nxt = GNT_REF;
          if (gnt_nxt != GNT_NONE) state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT_HI;
      WAIT_HI: if (mc_busy)  state_nxt = WAIT_LO;
      WAIT_LO: if (!mc_busy) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        consume   = (grant == GNT_REF);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      lat_we    <= 1'b0;
      lat_hi    <= 1'b0;
      lat_addr  <= '0;
      lat_din   <= '0;
      lat_wdm   <= '0;
      vdp_rdata <= '0;
      hr_rdata  <= '0;
    end else begin
      state <= state_nxt;
      // Request fields are frozen here; later changes by the client are ignored.
      if (state == IDLE && state_nxt == ISSUE) begin
        grant <= gnt_nxt;
        case (gnt_nxt)
          GNT_VDP: begin
            lat_we   <= vdp_we;
            lat_hi   <= vdp_addr[0];
            lat_addr <= {7'b0, vdp_addr[16:1]};
            lat_din  <= {vdp_wdata, vdp_wdata};
            lat_wdm  <= {~vdp_addr[0], vdp_addr[0]};
          end
          GNT_HR: begin
            lat_we   <= 1'b0;
            lat_hi   <= 1'b0;
            lat_addr <= {6'b0, hr_addr};
            lat_din  <= '0;
            lat_wdm  <= 2'b00;
          end
          default: begin
            lat_we   <= 1'b0;
            lat_hi   <= 1'b0;
            lat_addr <= '0;
            lat_din  <= '0;
            lat_wdm  <= 2'b00;
          end
        endcase
      end
      if (state == WAIT_LO && !mc_busy) begin
        if (grant == GNT_VDP && !lat_we) vdp_rdata <= lat_hi ? mc_dout[15:8] : mc_dout[7:0];
        if (grant == GNT_HR)             hr_rdata  <= mc_dout32;
      end
    end
  end

  assign issue      = (state == ISSUE);
  assign mc_read    = issue && ((grant == GNT_VDP && !lat_we) || grant == GNT_HR);
  assign mc_write   = issue && grant == GNT_VDP && lat_we;
  assign mc_refresh = issue && grant == GNT_REF;
  assign mc_addr    = issue ? lat_addr : '0;
  assign mc_din     = issue ? lat_din : '0;
  assign mc_wdm     = issue ? lat_wdm : 2'b00;
  assign vdp_ack    = (state == DONE) && (grant == GNT_VDP);
  assign hr_ack     = (state == DONE) && (grant == GNT_HR);
  assign dbg_state  = state;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: memory_controller model with fixed busy length, strobe and ack
// scoreboards, directed steps covering writes, byte reads, priority, refresh and reset.
`timescale 1ns/1ps
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int RI     = 8;
  localparam int BUSY_N = 2;
  localparam int SW     = 43;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        vdp_req, vdp_we, vdp_ack, hr_req, hr_ack;
  logic [16:0] vdp_addr, hr_addr;
  logic [7:0]  vdp_wdata, vdp_rdata;
  logic [31:0] hr_rdata, mc_dout32;
  logic        mc_read, mc_write, mc_refresh, mc_busy;
  logic [22:0] mc_addr;
  logic [15:0] mc_din, mc_dout;
  logic [1:0]  mc_wdm;
  logic [2:0]  refresh_debt;
  arb_state_t  dbg_state;

  vram_arbiter #(.REFRESH_INTERVAL(RI), .MAX_PENDING(4)) dut (
    .clk(clk), .reset(reset),
    .vdp_req(vdp_req), .vdp_we(vdp_we), .vdp_addr(vdp_addr), .vdp_wdata(vdp_wdata),
    .vdp_rdata(vdp_rdata), .vdp_ack(vdp_ack),
    .hr_req(hr_req), .hr_addr(hr_addr), .hr_rdata(hr_rdata), .hr_ack(hr_ack),
    .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh), .mc_addr(mc_addr),
    .mc_din(mc_din), .mc_wdm(mc_wdm), .mc_dout(mc_dout), .mc_dout32(mc_dout32),
    .mc_busy(mc_busy), .refresh_debt(refresh_debt), .dbg_state(dbg_state)
  );

  // scoreboard: {kind(write,read), addr, din, wdm}; {is_read, byte}; word
  logic [SW-1:0] exp_strb_q[$];
  logic [8:0]    exp_vdp_q[$];
  logic [31:0]   exp_hr_q[$];

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, strobe_cyc = 0, ref_cnt = 0, vdp_acks = 0, hr_acks = 0;
  int t5_refs = 0, max_debt = 0;
  bit in_t5 = 1'b0, prev_strobe = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // memory_controller model plus output monitor, sampled on the falling edge
  task automatic mc_monitor();
    int busy_left = 0;
    logic [SW-1:0] e;
    logic [8:0] ev;
    bit cur;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy_left > 0) begin mc_busy = 1'b1; busy_left--; end
      else mc_busy = 1'b0;
      cur = mc_read || mc_write || mc_refresh;
      if (cur) begin
        busy_left = BUSY_N;
        check("strobe_one_cycle", prev_strobe, 1'b0);
      end
      prev_strobe = cur;
      if (mc_read || mc_write) begin
        strobe_cyc = cyc;
        check("strobe_expected", exp_strb_q.size() != 0, 1'b1);
        if (exp_strb_q.size() != 0) begin
          e = exp_strb_q.pop_front();
          check("strobe_kind", {mc_write, mc_read}, e[42:41]);
          check("strobe_addr", mc_addr, e[40:18]);
          check("strobe_wdm", mc_wdm, e[1:0]);
          if (mc_write) check("strobe_din", mc_din, e[17:2]);
        end
      end
      if (mc_refresh) begin
        ref_cnt++;
        if (in_t5) begin
          t5_refs++;
          check("t5_refresh_urgent", refresh_debt >= 3'd4, 1'b1);
        end
      end
      if (in_t5 && int'(refresh_debt) > max_debt) max_debt = int'(refresh_debt);
      if (vdp_ack) begin
        vdp_acks++;
        check("vdp_ack_latency", cyc - strobe_cyc, BUSY_N + 2);
        check("vdp_ack_expected", exp_vdp_q.size() != 0, 1'b1);
        if (exp_vdp_q.size() != 0) begin
          ev = exp_vdp_q.pop_front();
          if (ev[8]) check("vdp_rdata", vdp_rdata, ev[7:0]);
        end
      end
      if (hr_ack) begin
        hr_acks++;
        check("hr_ack_latency", cyc - strobe_cyc, BUSY_N + 2);
        check("hr_ack_expected", exp_hr_q.size() != 0, 1'b1);
        if (exp_hr_q.size() != 0) check("hr_rdata", hr_rdata, exp_hr_q.pop_front());
      end
    end
  endtask

  // driver tasks
  task automatic wait_ack(input bit hr, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(hr ? hr_ack : vdp_ack) && n < 200);
    check({tag, "_ack_seen"}, hr ? hr_ack : vdp_ack, 1'b1);
  endtask

  task automatic wait_debt_zero(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (refresh_debt != 3'd0 && n < 100);
    check({tag, "_debt_zero"}, refresh_debt, 3'd0);
  endtask

  task automatic vdp_access(input bit we, input logic [16:0] a, input logic [7:0] d,
                            input logic [15:0] dout, input string tag);
    logic [7:0] rb;
    @(negedge clk);
    mc_dout = dout;
    vdp_we = we; vdp_addr = a; vdp_wdata = d;
    exp_strb_q.push_back({we, !we, {7'b0, a[16:1]}, {d, d}, {~a[0], a[0]}});
    rb = a[0] ? dout[15:8] : dout[7:0];
    exp_vdp_q.push_back({!we, rb});
    vdp_req = 1'b1;
    wait_ack(1'b0, tag);
    vdp_req = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_strobes"}, {mc_read, mc_write, mc_refresh, vdp_ack, hr_ack}, 5'd0);
    check({tag, "_mc_bus"}, {mc_addr, mc_din, mc_wdm}, 41'd0);
    check({tag, "_rdata"}, {vdp_rdata, hr_rdata}, 40'd0);
    check({tag, "_debt"}, refresh_debt, 3'd0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    int h0, v0, r0, n, mx;
    bit seen;
    reset = 1'b1; mc_busy = 1'b0;
    vdp_req = 1'b0; vdp_we = 1'b0; vdp_addr = '0; vdp_wdata = '0;
    hr_req = 1'b0; hr_addr = '0; mc_dout = '0; mc_dout32 = '0;
    fork mc_monitor(); join_none
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // 1: VDP write to odd byte
    vdp_access(1'b1, 17'h00003, 8'hA5, 16'h0000, "t1_write");
    // 2: VDP byte reads, low then high
    vdp_access(1'b0, 17'h00002, 8'h00, 16'h1234, "t2_read_lo");
    vdp_access(1'b0, 17'h00003, 8'h00, 16'h1234, "t2_read_hi");
    vdp_access(1'b0, 17'h1ABCD, 8'h00, 16'($urandom_range(0, 16'hFFFF)), "t2_read_rand");

    // 3: simultaneous requests, hr wins
    @(negedge clk);
    mc_dout32 = 32'hDEADBEEF; mc_dout = 16'h5A3C;
    hr_addr = 17'h1FFFF; vdp_we = 1'b0; vdp_addr = 17'h00004;
    exp_strb_q.push_back({2'b01, 23'h01FFFF, 16'h0000, 2'b00});
    exp_strb_q.push_back({2'b01, 23'h000002, 16'h0000, 2'b10});
    exp_hr_q.push_back(32'hDEADBEEF);
    exp_vdp_q.push_back({1'b1, 8'h3C});
    h0 = hr_acks; v0 = vdp_acks;
    hr_req = 1'b1; vdp_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!hr_ack && !vdp_ack && n < 200);
    check("t3_hr_first", {hr_ack, vdp_ack}, 2'b10);
    hr_req = 1'b0;
    wait_ack(1'b0, "t3_vdp");
    vdp_req = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_one_hr_ack", hr_acks - h0, 1);
    check("t3_one_vdp_ack", vdp_acks - v0, 1);

    // 4: idle clients, one refresh per interval
    wait_debt_zero("t4_pre");
    repeat (2 * RI) @(negedge clk);
    r0 = ref_cnt; mx = 0;
    for (int i = 0; i < 8 * RI; i++) begin
      @(negedge clk);
      if (int'(refresh_debt) > mx) mx = int'(refresh_debt);
    end
    check("t4_refresh_count", ref_cnt - r0, 8);
    check("t4_debt_bounded", mx <= 1, 1'b1);
    wait_debt_zero("t4_post");

    // 5: hr_req held continuously; refresh only when urgent
    @(negedge clk);
    seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      hr_addr = 17'($urandom_range(0, 17'h1FFFF));
      mc_dout32 = $urandom;
      exp_hr_q.push_back(mc_dout32);
      exp_strb_q.push_back({2'b01, {6'b0, hr_addr}, 16'h0000, 2'b00});
      hr_req = 1'b1;
      wait_ack(1'b1, "t5_hr");
      if (!seen) begin in_t5 = 1'b1; seen = 1'b1; end
    end
    hr_req = 1'b0;
    in_t5 = 1'b0;
    check("t5_refresh_seen", t5_refs >= 1, 1'b1);
    check("t5_debt_reached_4", max_debt >= 4, 1'b1);
    check("t5_debt_max_5", max_debt <= 5, 1'b1);
    wait_debt_zero("t5_post");

    // 6: reset in WAIT_LO of a VDP read aborts without ack
    @(negedge clk);
    mc_dout = 16'hBEEF; vdp_we = 1'b0; vdp_addr = 17'h00010;
    exp_strb_q.push_back({2'b01, 23'h000008, 16'h0000, 2'b10});
    v0 = vdp_acks;
    vdp_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (dbg_state != WAIT_LO && n < 200);
    check("t6_reached_wait_lo", dbg_state, WAIT_LO);
    reset = 1'b1;
    @(negedge clk);
    check_zero("t6_reset");
    vdp_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_vdp_ack", vdp_acks - v0, 0);

    check("queues_drained", exp_strb_q.size() + exp_vdp_q.size() + exp_hr_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
